mux_rr_arbiter: RTL

//  Round-robin arbiter plus N:1 stream mux: shares one WIDTH-bit output channel among N requesters.

---
 rtl/mux_arb_pkg.sv | 15 +
 rtl/rr_priority_sel.sv | 30 +++
 rtl/mux_rr_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the arbiter FSM encoding and the pointer-advance function.
package mux_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Next round-robin start position after serving requester ptr.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Rotating priority encoder: first set req bit scanning ptr, ptr+1, ... mod N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; consumer decides when to sample idx/found.
module rr_priority_sel #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [SELW-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = SELW'((int'(ptr) + k) % N);
            if (req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter + N:1 stream mux into one registered output slice (MUX_ARB_PKT_LOCK_EN: packet-atomic grants).
// Latency: request in IDLE -> in_ready next cycle -> out_valid the cycle after; 1 beat/cycle while granted.
// Backpressure: granted in_ready = !out_valid || out_ready; slice holds data stable while out_ready is low.
module mux_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_sel
);

    import mux_arb_pkg::*;

    localparam int SELW = $clog2(N);

    arb_state_e      state;
    arb_state_e      state_nxt;
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] win_idx;
    logic            win_found;
    logic            slot_free;
    logic            accept;
    logic            release_grant;

    rr_priority_sel #(
        .N    (N),
        .SELW (SELW)
    ) u_sel (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .idx   (win_idx),
        .found (win_found)
    );

    // Output slice can take a beat when empty or draining this cycle.
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = '0;
        accept        = 1'b0;
        release_grant = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (win_found) begin
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                in_ready[out_sel] = slot_free;
                accept            = in_valid[out_sel] && slot_free;
`ifdef MUX_ARB_PKT_LOCK_EN
                release_grant     = accept && in_last[out_sel];
`else
                release_grant     = accept;
`endif
                if (release_grant) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (state == ARB_IDLE && win_found) begin
                out_sel <= win_idx;
            end
            if (release_grant) begin
                rr_ptr <= SELW'(rr_next(int'(out_sel), N));
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(out_sel)*WIDTH +: WIDTH];
                out_last  <= in_last[out_sel];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
